// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Serialises instruction-fetch and data requests from the pipelined datapath
// onto a single-port RAM and answers them with one-cycle ihit/dhit pulses.
// Data requests win over instruction requests. An access that sees no ram_ack
// within TIMEOUT+1 cycles is aborted. The aborted access still gets its hit,
// err pulses with that hit, and a read returns ERR_WORD.
//
// Optional feature macro: MEM_ARBITER_IBUF_EN
//   When defined, a one-entry instruction buffer answers a repeated fetch of
//   the last filled address without touching the RAM.
//
// Ports
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   iREN, iaddr        instruction fetch request / address (held until ihit)
//   dREN, dWEN         data read / write request (held until dhit)
//   daddr, dstore      data address / write data
//   ihit, dhit, err    registered one-cycle completion and error pulses
//   iload, dload       registered fetched instruction / load data
//   ram_ren, ram_wen   RAM strobes (combinational from state)
//   ram_addr,ram_wdata RAM address / write data (latched request)
//   ram_rdata, ram_ack RAM read data and one-cycle completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        err,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;
    logic          we_q, we_d;
    logic          ihit_q, ihit_d;
    logic          dhit_q, dhit_d;
    logic          err_q, err_d;
    logic          done_s;      // access leaves D_ACC/I_ACC this cycle
    logic          timeout_s;   // ...and it leaves because it ran out of time

`ifdef MEM_ARBITER_IBUF_EN
    logic          buf_valid_q, buf_valid_d;
    logic [31:0]   buf_addr_q, buf_addr_d;
    logic [31:0]   buf_data_q, buf_data_d;
`endif

    // Access completion: ram_ack wins over a coincident timeout.
    always_comb begin
        done_s    = 1'b0;
        timeout_s = 1'b0;
        if ((state_q == D_ACC) || (state_q == I_ACC)) begin
            if (ram_ack) begin
                done_s = 1'b1;
            end else if (cnt_q == TIMEOUT_C) begin
                done_s    = 1'b1;
                timeout_s = 1'b1;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // Next-state, request latching, hit/err pulses and load capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        iload_d = iload_q;
        dload_d = dload_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MEM_ARBITER_IBUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    wdata_d = dstore;
                    we_d    = dWEN;   // write wins when both are raised
                    state_d = D_ACC;
                end else if (iREN) begin
`ifdef MEM_ARBITER_IBUF_EN
                    if (buf_valid_q && (iaddr == buf_addr_q)) begin
                        iload_d = buf_data_q;
                        ihit_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = iaddr;
                        state_d = I_ACC;
                    end
`else
                    addr_d  = iaddr;
                    state_d = I_ACC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            D_ACC, I_ACC: begin
                if (done_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = RESP;
                    err_d   = timeout_s;
                    if (state_q == I_ACC) begin
                        ihit_d  = 1'b1;
                        iload_d = timeout_s ? ERR_WORD : ram_rdata;
`ifdef MEM_ARBITER_IBUF_EN
                        if (!timeout_s) begin
                            buf_valid_d = 1'b1;
                            buf_addr_d  = addr_q;
                            buf_data_d  = ram_rdata;
                        end else begin
                            buf_valid_d = buf_valid_q;
                        end
`endif
                    end else begin
                        dhit_d = 1'b1;
                        if (!we_q) begin
                            dload_d = timeout_s ? ERR_WORD : ram_rdata;
                        end else begin
                            dload_d = dload_q;
`ifdef MEM_ARBITER_IBUF_EN
                            // A write to the buffered word makes the copy stale.
                            if (addr_q[31:2] == buf_addr_q[31:2]) begin
                                buf_valid_d = 1'b0;
                            end else begin
                                buf_valid_d = buf_valid_q;
                            end
`endif
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                // No request sampling here: held request lines cannot re-trigger.
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // RAM interface driven straight from the state and latched request.
    always_comb begin
        ram_ren   = ((state_q == D_ACC) && !we_q) || (state_q == I_ACC);
        ram_wen   = (state_q == D_ACC) && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            iload_q <= 32'h0000_0000;
            dload_q <= 32'h0000_0000;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_ARBITER_IBUF_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 32'h0000_0000;
            buf_data_q  <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            err_q   <= err_d;
`ifdef MEM_ARBITER_IBUF_EN
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign ihit  = ihit_q;
    assign dhit  = dhit_q;
    assign err   = err_q;
    assign iload = iload_q;
    assign dload = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (TIMEOUT = 4). A transaction-level model
// tracks which request is being served, how long its access may last, and
// what each load register must hold; every cycle the DUT outputs are compared
// against it. A small RAM responder with programmable wait states answers the
// strobes. Literal expectations pin hit cycles and load values of the
// hand-computed scenarios.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRW = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN, ram_ack;
    logic [31:0] iaddr, daddr, dstore, ram_rdata;
    logic        ihit, dhit, err, ram_ren, ram_wen;
    logic [31:0] iload, dload, ram_addr, ram_wdata;

    mem_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
        .iload(iload), .dload(dload), .err(err), .ram_ren(ram_ren),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_fail = 0, cyc = 0;
    int n_ihit, n_dhit, n_err, ihit_cyc, dhit_cyc, err_cyc, ren_cnt, wen_cnt;
    int ram_waits = 0, wcnt = 0;
    bit ram_mute = 1'b0;
    logic [31:0] mem [logic [31:0]];

    // Model: 0 = free, 1 = access in flight, 2 = answering
    int          m_st = 0, m_start = 0;
    bit          m_isd = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, e_iload = 32'h0, e_dload = 32'h0;
    bit          m_bv = 1'b0;
    logic [31:0] m_ba = 32'h0, m_bd = 32'h0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Advance the model over one clock edge using the inputs present before it.
    task automatic model_step(input bit r, input bit dr, input bit dw, input bit ir,
                              input bit ak, input logic [31:0] da, input logic [31:0] ds,
                              input logic [31:0] ia, input int c);
        if (r) begin
            m_st = 0; e_iload = 32'h0; e_dload = 32'h0; m_bv = 1'b0;
        end else if (m_st == 0) begin
            if (dr || dw) begin
                m_st = 1; m_isd = 1'b1; m_we = dw; m_addr = da; m_wdata = ds; m_start = c + 1;
            end else if (ir) begin
`ifdef MEM_ARBITER_IBUF_EN
                if (m_bv && (m_ba == ia)) begin
                    e_iload = m_bd; m_st = 2; m_isd = 1'b0; m_err = 1'b0;
                end else begin
                    m_st = 1; m_isd = 1'b0; m_we = 1'b0; m_addr = ia; m_start = c + 1;
                end
`else
                m_st = 1; m_isd = 1'b0; m_we = 1'b0; m_addr = ia; m_start = c + 1;
`endif
            end
        end else if (m_st == 1) begin
            // An access may occupy at most TO+1 cycles.
            if (ak || (c == m_start + TO)) begin
                m_err = !ak;
                m_st  = 2;
                if (!m_isd) begin
                    e_iload = ak ? mem_rd(m_addr) : ERRW;
`ifdef MEM_ARBITER_IBUF_EN
                    if (ak) begin m_bv = 1'b1; m_ba = m_addr; m_bd = e_iload; end
`endif
                end else if (!m_we) begin
                    e_dload = ak ? mem_rd(m_addr) : ERRW;
                end else begin
`ifdef MEM_ARBITER_IBUF_EN
                    if (m_ba[31:2] == m_addr[31:2]) m_bv = 1'b0;
`endif
                end
            end
        end else begin
            m_st = 0;
        end
    endtask

    task automatic check_all();
        bit rs, ac;
        rs = (m_st == 2);
        ac = (m_st == 1);
        chk("ihit", 32'(ihit), 32'(rs && !m_isd));
        chk("dhit", 32'(dhit), 32'(rs && m_isd));
        chk("err", 32'(err), 32'(rs && m_err));
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
        chk("ram_ren", 32'(ram_ren), 32'(ac && !(m_isd && m_we)));
        chk("ram_wen", 32'(ram_wen), 32'(ac && m_isd && m_we));
        if (ac) chk("ram_addr", ram_addr, m_addr);
        if (ac && m_isd && m_we) chk("ram_wdata", ram_wdata, m_wdata);
        if (ihit === 1'b1) begin n_ihit++; ihit_cyc = cyc; end
        if (dhit === 1'b1) begin n_dhit++; dhit_cyc = cyc; end
        if (err === 1'b1) begin n_err++; err_cyc = cyc; end
        if (ram_ren === 1'b1) ren_cnt++;
        if (ram_wen === 1'b1) wen_cnt++;
    endtask

    // RAM responder: ack after ram_waits stall cycles unless muted.
    task automatic ram_drive();
        if (((ram_ren === 1'b1) || (ram_wen === 1'b1)) && !ram_mute) begin
            if (wcnt >= ram_waits) begin
                ram_ack   = 1'b1;
                ram_rdata = mem_rd(ram_addr);
                if (ram_wen === 1'b1) mem[ram_addr] = ram_wdata;
                wcnt = 0;
            end else begin
                ram_ack = 1'b0;
                wcnt++;
            end
        end else begin
            ram_ack   = 1'b0;
            ram_rdata = 32'h0;
            wcnt      = 0;
        end
    endtask

    task automatic tick();
        bit r, dr, dw, ir, ak;
        logic [31:0] da, ds, ia;
        r = RST; dr = dREN; dw = dWEN; ir = iREN; ak = ram_ack;
        da = daddr; ds = dstore; ia = iaddr;
        @(posedge CLK);
        model_step(r, dr, dw, ir, ak, da, ds, ia, cyc);
        cyc++;
        @(negedge CLK);
        check_all();
        ram_drive();
        // Requester drops the served line once its hit is due.
        if (m_st == 2) begin
            if (m_isd) begin dREN = 1'b0; dWEN = 1'b0; end
            else iREN = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        cyc = 0; n_ihit = 0; n_dhit = 0; n_err = 0; ihit_cyc = -1; dhit_cyc = -1;
        err_cyc = -1; ren_cnt = 0; wen_cnt = 0;
    endtask

    task automatic run_idle(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && (n < budget)) begin
            tick();
            n++;
            done = (m_st == 0) && !iREN && !dREN && !dWEN;
        end
        chk("idle_bound", 32'(done), 32'd1);
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ack = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ram_rdata = 32'h0;
        clear_stats();
        mem[32'h0000_0100] = 32'h8C22_0004;
        mem[32'h0000_0200] = 32'h1111_2222;
        mem[32'h0000_0040] = 32'h2000_0040;

        // Reset state
        ticks(2);
        RST = 1'b0;
        tick();
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);

        // Lone fetch, ack in first access cycle
        ram_waits = 0; iaddr = 32'h100; iREN = 1'b1; clear_stats();
        ticks(3);
        chk("fetch_ihit_cyc", 32'(ihit_cyc), 32'd2);
        chk("fetch_nihit", 32'(n_ihit), 32'd1);
        chk("fetch_ndhit", 32'(n_dhit), 32'd0);
        chk("fetch_ren_cycles", 32'(ren_cnt), 32'd1);
        chk("fetch_iload", iload, 32'h8C22_0004);

        // Simultaneous data and instruction requests, 2 wait states each
        ram_waits = 2; iaddr = 32'h180; iREN = 1'b1; daddr = 32'h200; dREN = 1'b1;
        clear_stats();
        ticks(11);
        chk("prio_dhit_cyc", 32'(dhit_cyc), 32'd4);
        chk("prio_ihit_cyc", 32'(ihit_cyc), 32'd9);
        chk("prio_ndhit", 32'(n_dhit), 32'd1);
        chk("prio_nihit", 32'(n_ihit), 32'd1);
        chk("prio_dload", dload, 32'h1111_2222);

        // Write with one wait state
        ram_waits = 1; daddr = 32'h300; dstore = 32'hDEAD_BEEF; dWEN = 1'b1; clear_stats();
        ticks(4);
        chk("wr_dhit_cyc", 32'(dhit_cyc), 32'd3);
        chk("wr_mem", mem_rd(32'h300), 32'hDEAD_BEEF);
        chk("wr_dload_kept", dload, 32'h1111_2222);
        chk("wr_ren_cycles", 32'(ren_cnt), 32'd0);
        chk("wr_wen_cycles", 32'(wen_cnt), 32'd2);

        // Read and write raised together: the write wins
        ram_waits = 0; daddr = 32'h304; dstore = 32'h0BAD_F00D; dREN = 1'b1; dWEN = 1'b1;
        clear_stats();
        ticks(3);
        chk("rw_mem", mem_rd(32'h304), 32'h0BAD_F00D);
        chk("rw_ren_cycles", 32'(ren_cnt), 32'd0);
        chk("rw_ndhit", 32'(n_dhit), 32'd1);

        // Timeout: no ack ever
        ram_mute = 1'b1; daddr = 32'h208; dREN = 1'b1; clear_stats();
        ticks(7);
        chk("to_dhit_cyc", 32'(dhit_cyc), 32'd6);
        chk("to_err_cyc", 32'(err_cyc), 32'd6);
        chk("to_nerr", 32'(n_err), 32'd1);
        chk("to_dload", dload, 32'hBAD1_BAD1);

        // Reset in the second access cycle, then a stray ack
        daddr = 32'h20C; dREN = 1'b1; clear_stats();
        ticks(2);
        RST = 1'b1; dREN = 1'b0;
        tick();
        chk("rst_mid_ren", 32'(ram_ren), 32'd0);
        RST = 1'b0;
        ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
        ticks(4);
        chk("rst_mid_ndhit", 32'(n_dhit), 32'd0);
        chk("rst_mid_dload", dload, 32'h0);
        ram_mute = 1'b0;

        // Mixed traffic with varying wait states
        for (int k = 0; k < 6; k++) begin
            ram_waits = k % 3;
            if (k % 3 == 0) begin
                daddr = 32'h400 + 32'(4 * k); dREN = 1'b1;
            end else if (k % 3 == 1) begin
                daddr = 32'h400 + 32'(4 * (k - 1)); dstore = 32'h5500_0000 + 32'(k); dWEN = 1'b1;
            end else begin
                iaddr = 32'h500 + 32'(4 * k); iREN = 1'b1;
            end
            run_idle(20);
        end

`ifdef MEM_ARBITER_IBUF_EN
        // Instruction buffer: repeat fetch served from the buffer until a write hits it
        ram_waits = 1; iaddr = 32'h40; iREN = 1'b1;
        run_idle(20);
        iREN = 1'b1; clear_stats();
        ticks(2);
        chk("ibuf_ihit_cyc", 32'(ihit_cyc), 32'd1);
        chk("ibuf_ren_cycles", 32'(ren_cnt), 32'd0);
        chk("ibuf_iload", iload, 32'h2000_0040);
        daddr = 32'h40; dstore = 32'h0000_1234; dWEN = 1'b1;
        run_idle(20);
        iREN = 1'b1; clear_stats();
        run_idle(20);
        chk("ibuf_refetch_ren", 32'(ren_cnt != 0), 32'd1);
        chk("ibuf_refetch_iload", iload, 32'h0000_1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the ihit/dhit handshake that the hazard unit consumes.
- Accepts instruction-fetch requests (iREN) and data requests (dREN/dWEN) from the pipelined datapath, serialises them onto a single-port RAM, and returns ihit/dhit with load data.
- Sits between the datapath request lines and the RAM model; data requests take priority over instruction requests.

Parameters:
- TIMEOUT, 64: maximum cycles spent in an access state waiting for ram_ack before aborting the access.
- ERR_WORD, 32'hBAD1BAD1: load value returned on a timed-out read.

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction fetch request; held until ihit.
- iaddr  in  32  fetch address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  32  data address.
- dstore  in  32  write data.
- ihit  out  1  one-cycle pulse; instruction access complete.
- dhit  out  1  one-cycle pulse; data access complete.
- iload  out  32  fetched instruction, registered.
- dload  out  32  read data, registered.
- err  out  1  one-cycle pulse, coincident with the hit of a timed-out access.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid when ram_ack is high.
- ram_ack  in  1  RAM completion; one-cycle pulse.

Behaviour:
- Reset is synchronous and active-high on CLK. On reset:
  - state = IDLE.
  - ihit, dhit, err = 0.
  - iload, dload = 0.
  - wait counter = 0.
  - latched request registers cleared.
  - ram_ren, ram_wen = 0, ram_addr, ram_wdata = 0 from the following cycle.
  - Reset during any state aborts the in-flight access with no hit.
- FSM states: IDLE, D_ACC, I_ACC, RESP.
- IDLE:
  - If dREN or dWEN is high: latch daddr, dstore and we = dWEN, then go to D_ACC. When dREN and dWEN are both high, the write wins.
  - Else if iREN is high: latch iaddr, then go to I_ACC.
  - Else stay in IDLE.
  - Simultaneous instruction and data requests: data is served first; the instruction request is taken in a later IDLE cycle.
- D_ACC / I_ACC:
  - RAM outputs are combinational from state and the latched registers:
    - ram_ren = (D_ACC & !we) | I_ACC.
    - ram_wen = D_ACC & we.
    - ram_addr = the latched address.
    - ram_wdata = the latched dstore.
  - Every cycle without ram_ack increments the wait counter (width clog2(TIMEOUT+1)).
  - On ram_ack: capture ram_rdata into dload (data read only) or iload, then go to RESP. Writes leave dload unchanged.
  - If the counter reaches TIMEOUT with no ram_ack: go to RESP with the error flag set. Reads load ERR_WORD.
  - Counter clears on entry to RESP.
- RESP:
  - ihit or dhit (matching the served request) high for exactly this cycle; err high here if the access timed out.
  - RAM strobes are low.
  - Next state is IDLE unconditionally. No new request is sampled in RESP, so the requestor's changing lines never cause a double hit.
- Latency: request high in cycle 0 (IDLE); RAM strobes in cycle 1; ram_ack in cycle 1 gives the hit in cycle 2. Minimum latency is 2 cycles, plus one cycle per wait state.
- Request dropped mid-access: the access completes and the hit still pulses; the datapath ignores it.
- ram_ack outside D_ACC/I_ACC is ignored.
- iload and dload hold their values between accesses.

Optional Feature:
- Macro: MEM_ARBITER_IBUF_EN.
- Defined: adds a one-entry instruction buffer (buf_valid, buf_addr, buf_data).
  - Every completed non-error I_ACC fill sets buf_valid and captures the address and data.
  - IDLE with iREN, no data request, buf_valid and iaddr == buf_addr: load iload from buf_data and go directly to RESP. ihit follows 1 cycle after the request; no RAM strobe is issued.
  - A completed D_ACC write with daddr[31:2] == buf_addr[31:2] clears buf_valid.
  - Reset clears buf_valid.
- Undefined: no buffer logic; every fetch goes through I_ACC.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x100; RAM acks in the first I_ACC cycle with 0x8C220004 -> ram_ren high 1 cycle, ram_addr=0x100, ihit pulse in cycle 2, iload=0x8C220004, dhit stays 0.
- Priority: iREN=1 and dREN=1 (daddr=0x200) in the same cycle, 2 wait states each -> dhit in cycle 4 with dload=RAM[0x200], then ihit in cycle 9; exactly one pulse each.
- Write: dWEN=1, daddr=0x300, dstore=0xDEADBEEF -> ram_wen=1, ram_wdata=0xDEADBEEF, ram_ren=0, dhit 1 cycle after ack, dload unchanged.
- Timeout with TIMEOUT=4 and no ram_ack: dREN=1 -> dhit and err both pulse in cycle 6, dload=0xBAD1BAD1, FSM back in IDLE.
- Reset mid-access: RST=1 in the second D_ACC cycle -> next cycle ram_ren=0, FSM in IDLE, no dhit ever; a late ram_ack is ignored.
- MEM_ARBITER_IBUF_EN: fetch 0x40 twice -> second ihit after 1 cycle with no ram_ren. After a write to 0x40, a third fetch to 0x40 issues ram_ren again.
